// File: rtl/histogram_esitleme_lut.sv
// Builds a 256-entry histogram-equalisation LUT from a finished frame histogram (CDF, then per-bin divide).
// Latency: bitti_o 257 + 1 + 256*(3+NUM_BIT) cycles after basla_i is accepted; LUT read port has 1-cycle latency.
// Backpressure: none; basla_i is ignored while busy. Optional rounding via ESITLEME_YUVARLA_EN.
module histogram_esitleme_lut #(
    parameter int PIXEL_BIT = 8,
    parameter int SAYAC_BIT = 17,
    parameter int PIKSEL_N  = 76800,
    parameter int NUM_BIT   = 25
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 basla_i,
    output logic                 hist_oku_o,
    output logic [PIXEL_BIT-1:0] hist_adres_o,
    input  logic [SAYAC_BIT-1:0] hist_veri_i,
    output logic                 mesgul_o,
    output logic                 bitti_o,
    output logic                 lut_gecerli_o,
    output logic                 hata_o,
    input  logic [PIXEL_BIT-1:0] lut_adres_i,
    output logic [PIXEL_BIT-1:0] lut_veri_o
);

    localparam int DERINLIK    = 1 << PIXEL_BIT;
    localparam int DIV_CNT_BIT = $clog2(NUM_BIT + 1);
    localparam logic [SAYAC_BIT-1:0]   SAYAC_MAX  = '1;
    localparam logic [SAYAC_BIT-1:0]   PIKSEL_N_W = SAYAC_BIT'(PIKSEL_N);
    localparam logic [PIXEL_BIT:0]     TOPLA_SON  = (PIXEL_BIT+1)'(DERINLIK);
    localparam logic [PIXEL_BIT:0]     ADRES_SON  = (PIXEL_BIT+1)'(DERINLIK - 1);
    localparam logic [DIV_CNT_BIT-1:0] DIV_SON    = DIV_CNT_BIT'(NUM_BIT);

    typedef enum logic [2:0] {BOSTA, TOPLA, HAZIRLA, OKU, BOL, YAZ, BITTI} durum_t;

    durum_t                 durum_q, durum_d;
    logic [PIXEL_BIT:0]     sayac_q, sayac_d;
    logic [DIV_CNT_BIT-1:0] div_cnt_q, div_cnt_d;
    logic [SAYAC_BIT-1:0]   acc_q, acc_d, cdf_min_q, cdf_min_d, payda_q, payda_d, rem_q, rem_d;
    logic                   min_bulundu_q, min_bulundu_d, doyma_q, doyma_d;
    logic [NUM_BIT-1:0]     bolum_q, bolum_d;
    logic [PIXEL_BIT-1:0]   hist_adres_q, hist_adres_d, lut_veri_q, lut_veri_d;
    logic                   mesgul_q, mesgul_d, bitti_q, bitti_d, gecerli_q, gecerli_d, hata_q, hata_d;

    logic [SAYAC_BIT-1:0]   cdf_ram [DERINLIK];
    logic [PIXEL_BIT-1:0]   lut_ram [DERINLIK];
    logic [SAYAC_BIT-1:0]   cdf_oku_q;
    logic                   cdf_we, lut_we;
    logic [PIXEL_BIT-1:0]   cdf_wadr, lut_wdat, bin;

    logic [SAYAC_BIT:0]     toplam_genis;
    logic [SAYAC_BIT-1:0]   toplam, cdf_fark, fark;
    logic                   doyar, cikar;
    logic [SAYAC_BIT:0]     rem_kay;
    logic [NUM_BIT-1:0]     pay, pay_son;

    assign bin          = sayac_q[PIXEL_BIT-1:0];
    assign toplam_genis = {1'b0, acc_q} + {1'b0, hist_veri_i};
    assign doyar        = toplam_genis[SAYAC_BIT];
    assign toplam       = doyar ? SAYAC_MAX : toplam_genis[SAYAC_BIT-1:0];

    // Bins below cdf_min map to zero instead of wrapping negative.
    assign cdf_fark = cdf_oku_q - cdf_min_q;
    assign pay      = (cdf_oku_q < cdf_min_q) ? '0 : NUM_BIT'(cdf_fark) * NUM_BIT'(255);
`ifdef ESITLEME_YUVARLA_EN
    assign pay_son  = pay + NUM_BIT'(payda_q >> 1);
`else
    assign pay_son  = pay;
`endif

    // Restoring divider step: remainder always stays below payda, so SAYAC_BIT bits suffice.
    assign rem_kay = {rem_q, bolum_q[NUM_BIT-1]};
    assign cikar   = rem_kay >= {1'b0, payda_q};
    assign fark    = rem_kay[SAYAC_BIT-1:0] - payda_q;

    assign lut_veri_d = lut_ram[lut_adres_i];

    always_comb begin
        durum_d       = durum_q;
        sayac_d       = sayac_q;
        div_cnt_d     = div_cnt_q;
        acc_d         = acc_q;
        cdf_min_d     = cdf_min_q;
        min_bulundu_d = min_bulundu_q;
        doyma_d       = doyma_q;
        payda_d       = payda_q;
        rem_d         = rem_q;
        bolum_d       = bolum_q;
        hist_adres_d  = hist_adres_q;
        mesgul_d      = mesgul_q;
        bitti_d       = 1'b0;
        gecerli_d     = gecerli_q;
        hata_d        = hata_q;
        cdf_we        = 1'b0;
        cdf_wadr      = bin - PIXEL_BIT'(1);
        lut_we        = 1'b0;
        lut_wdat      = (|bolum_q[NUM_BIT-1:PIXEL_BIT]) ? '1 : bolum_q[PIXEL_BIT-1:0];
        if (payda_q == '0) lut_wdat = bin;
        unique case (durum_q)
            BOSTA: if (basla_i) begin
                durum_d       = TOPLA;
                mesgul_d      = 1'b1;
                gecerli_d     = 1'b0;
                hata_d        = 1'b0;
                sayac_d       = '0;
                acc_d         = '0;
                cdf_min_d     = '0;
                min_bulundu_d = 1'b0;
                doyma_d       = 1'b0;
                hist_adres_d  = '0;
            end
            TOPLA: begin
                sayac_d = sayac_q + (PIXEL_BIT+1)'(1);
                if (sayac_q < ADRES_SON) hist_adres_d = bin + PIXEL_BIT'(1);
                // Data for address sayac_q-1 is on hist_veri_i this cycle.
                if (sayac_q != '0) begin
                    acc_d   = toplam;
                    doyma_d = doyma_q | doyar;
                    cdf_we  = 1'b1;
                    if (!min_bulundu_q && toplam != '0) begin
                        cdf_min_d     = toplam;
                        min_bulundu_d = 1'b1;
                    end
                end
                if (sayac_q == TOPLA_SON) durum_d = HAZIRLA;
            end
            HAZIRLA: begin
                payda_d = (cdf_min_q >= PIKSEL_N_W) ? '0 : PIKSEL_N_W - cdf_min_q;
                hata_d  = doyma_q | (acc_q != PIKSEL_N_W);
                sayac_d = '0;
                durum_d = OKU;
            end
            OKU: begin
                div_cnt_d = '0;
                durum_d   = BOL;
            end
            BOL: begin
                if (div_cnt_q == '0) begin
                    rem_d   = '0;
                    bolum_d = pay_son;
                end else begin
                    rem_d   = cikar ? fark : rem_kay[SAYAC_BIT-1:0];
                    bolum_d = {bolum_q[NUM_BIT-2:0], cikar};
                end
                div_cnt_d = div_cnt_q + DIV_CNT_BIT'(1);
                if (div_cnt_q == DIV_SON) durum_d = YAZ;
            end
            YAZ: begin
                lut_we = 1'b1;
                if (bin == '1) begin
                    durum_d   = BITTI;
                    mesgul_d  = 1'b0;
                    gecerli_d = 1'b1;
                    bitti_d   = 1'b1;
                end else begin
                    sayac_d = sayac_q + (PIXEL_BIT+1)'(1);
                    durum_d = OKU;
                end
            end
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q       <= BOSTA;
            sayac_q       <= '0;
            div_cnt_q     <= '0;
            acc_q         <= '0;
            cdf_min_q     <= '0;
            min_bulundu_q <= 1'b0;
            doyma_q       <= 1'b0;
            payda_q       <= '0;
            rem_q         <= '0;
            bolum_q       <= '0;
            hist_adres_q  <= '0;
            mesgul_q      <= 1'b0;
            bitti_q       <= 1'b0;
            gecerli_q     <= 1'b0;
            hata_q        <= 1'b0;
            lut_veri_q    <= '0;
        end else begin
            durum_q       <= durum_d;
            sayac_q       <= sayac_d;
            div_cnt_q     <= div_cnt_d;
            acc_q         <= acc_d;
            cdf_min_q     <= cdf_min_d;
            min_bulundu_q <= min_bulundu_d;
            doyma_q       <= doyma_d;
            payda_q       <= payda_d;
            rem_q         <= rem_d;
            bolum_q       <= bolum_d;
            hist_adres_q  <= hist_adres_d;
            mesgul_q      <= mesgul_d;
            bitti_q       <= bitti_d;
            gecerli_q     <= gecerli_d;
            hata_q        <= hata_d;
            lut_veri_q    <= lut_veri_d;
        end
    end

    // RAMs are deliberately not reset; the CDF read port follows the current bin every cycle.
    always_ff @(posedge clk_i) begin
        if (cdf_we) cdf_ram[cdf_wadr] <= toplam;
        if (lut_we) lut_ram[bin] <= lut_wdat;
        cdf_oku_q <= cdf_ram[bin];
    end

    assign hist_oku_o    = (durum_q == TOPLA) && !sayac_q[PIXEL_BIT];
    assign hist_adres_o  = hist_adres_q;
    assign mesgul_o      = mesgul_q;
    assign bitti_o       = bitti_q;
    assign lut_gecerli_o = gecerli_q;
    assign hata_o        = hata_q;
    assign lut_veri_o    = lut_veri_q;

endmodule

// File: tb/tb_histogram_esitleme_lut.sv
// Directed bench for histogram_esitleme_lut: build latency, LUT contents, error flag and control corner cases.
module tb_histogram_esitleme_lut;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        basla_i = 1'b0;
    logic        hist_oku_o;
    logic [7:0]  hist_adres_o;
    logic [16:0] hist_veri_i = '0;
    logic        mesgul_o, bitti_o, lut_gecerli_o, hata_o;
    logic [7:0]  lut_adres_i = '0;
    logic [7:0]  lut_veri_o;

    logic [16:0] hist_mem [256];
    int checks = 0;
    int errors = 0;

    histogram_esitleme_lut dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .basla_i(basla_i),
        .hist_oku_o(hist_oku_o), .hist_adres_o(hist_adres_o), .hist_veri_i(hist_veri_i),
        .mesgul_o(mesgul_o), .bitti_o(bitti_o), .lut_gecerli_o(lut_gecerli_o), .hata_o(hata_o),
        .lut_adres_i(lut_adres_i), .lut_veri_o(lut_veri_o)
    );

    always #5 clk_i = ~clk_i;

    // Histogram memory: data appears one cycle after the read strobe.
    always @(posedge clk_i) if (hist_oku_o) hist_veri_i <= hist_mem[hist_adres_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < 256; i++) hist_mem[i] = 17'(val);
    endtask

    task automatic run_build(input string tag, output int lat);
        basla_i = 1'b1;
        @(posedge clk_i); #1;
        basla_i = 1'b0;
        chk({tag, "_busy"}, 32'(mesgul_o), 1);
        chk({tag, "_valid_low"}, 32'(lut_gecerli_o), 0);
        chk({tag, "_err_clr"}, 32'(hata_o), 0);
        lat = 0;
        while (bitti_o !== 1'b1 && lat < 8000) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic lut_oku(input int a, output int d);
        lut_adres_i = 8'(a);
        @(posedge clk_i); #1;
        d = int'(lut_veri_o);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(mesgul_o), 0);
        chk({tag, "_done"}, 32'(bitti_o), 0);
        chk({tag, "_valid"}, 32'(lut_gecerli_o), 0);
        chk({tag, "_err"}, 32'(hata_o), 0);
        chk({tag, "_hrd"}, 32'(hist_oku_o), 0);
        chk({tag, "_hadr"}, 32'(hist_adres_o), 0);
        chk({tag, "_lut"}, 32'(lut_veri_o), 0);
    endtask

    initial begin
        int lat, d, pulses, first;
        fill(0);

        // Reset state
        #23;
        chk_outputs_zero("rst");
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: flat histogram of 300 per bin gives an identity LUT
        fill(300);
        run_build("t1", lat);
        chk("t1_latency", 32'(lat), 7426);
        chk("t1_done", 32'(bitti_o), 1);
        chk("t1_busy_end", 32'(mesgul_o), 0);
        chk("t1_valid", 32'(lut_gecerli_o), 1);
        chk("t1_err", 32'(hata_o), 0);
        @(posedge clk_i); #1;
        chk("t1_done_pulse", 32'(bitti_o), 0);
        for (int v = 0; v < 256; v++) begin
            lut_oku(v, d);
            chk("t1_lut", 32'(d), 32'(v));
        end

        // 2: two-level frame
        fill(0);
        hist_mem[0] = 17'd38400;
        hist_mem[255] = 17'd38400;
        run_build("t2", lat);
        chk("t2_latency", 32'(lat), 7426);
        chk("t2_err", 32'(hata_o), 0);
        lut_oku(0, d);   chk("t2_lut0", 32'(d), 0);
        lut_oku(1, d);   chk("t2_lut1", 32'(d), 0);
        lut_oku(128, d); chk("t2_lut128", 32'(d), 0);
        lut_oku(254, d); chk("t2_lut254", 32'(d), 0);
        lut_oku(255, d); chk("t2_lut255", 32'(d), 255);

        // 3: single-valued frame -> identity bypass
        fill(0);
        hist_mem[100] = 17'd76800;
        run_build("t3", lat);
        chk("t3_latency", 32'(lat), 7426);
        chk("t3_err", 32'(hata_o), 0);
        lut_oku(37, d);  chk("t3_lut37", 32'(d), 37);
        lut_oku(0, d);   chk("t3_lut0", 32'(d), 0);
        lut_oku(100, d); chk("t3_lut100", 32'(d), 100);
        lut_oku(255, d); chk("t3_lut255", 32'(d), 255);

        // 4: total one short of a frame
        fill(300);
        hist_mem[7] = 17'd299;
        run_build("t4", lat);
        chk("t4_latency", 32'(lat), 7426);
        chk("t4_done", 32'(bitti_o), 1);
        chk("t4_err", 32'(hata_o), 1);
        chk("t4_valid", 32'(lut_gecerli_o), 1);
        lut_oku(0, d);   chk("t4_lut0", 32'(d), 0);
        lut_oku(6, d);   chk("t4_lut6", 32'(d), 6);
`ifdef ESITLEME_YUVARLA_EN
        lut_oku(10, d);  chk("t4_lut10", 32'(d), 10);
        lut_oku(255, d); chk("t4_lut255", 32'(d), 255);
`else
        lut_oku(10, d);  chk("t4_lut10", 32'(d), 9);
        lut_oku(255, d); chk("t4_lut255", 32'(d), 254);
`endif

        // 5: cdf_min of 1, then a three-level frame with a mid-value bin
        fill(0);
        hist_mem[0] = 17'd1;
        hist_mem[1] = 17'd76799;
        run_build("t5", lat);
        chk("t5_latency", 32'(lat), 7426);
        lut_oku(0, d); chk("t5_lut0", 32'(d), 0);
        lut_oku(1, d); chk("t5_lut1", 32'(d), 255);
        fill(0);
        hist_mem[10] = 17'd1000;
        hist_mem[50] = 17'd30000;
        hist_mem[200] = 17'd45800;
        run_build("t5b", lat);
        chk("t5b_err", 32'(hata_o), 0);
        lut_oku(9, d);   chk("t5b_lut9", 32'(d), 0);
        lut_oku(49, d);  chk("t5b_lut49", 32'(d), 0);
`ifdef ESITLEME_YUVARLA_EN
        lut_oku(50, d);  chk("t5b_lut50", 32'(d), 101);
        lut_oku(120, d); chk("t5b_lut120", 32'(d), 101);
`else
        lut_oku(50, d);  chk("t5b_lut50", 32'(d), 100);
        lut_oku(120, d); chk("t5b_lut120", 32'(d), 100);
`endif
        lut_oku(200, d); chk("t5b_lut200", 32'(d), 255);

        // 6a: second start during a build is ignored
        fill(300);
        basla_i = 1'b1;
        @(posedge clk_i); #1;
        basla_i = 1'b0;
        pulses = 0;
        first = 0;
        for (int n = 1; n <= 7700; n++) begin
            @(posedge clk_i); #1;
            if (bitti_o === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
            end
            if (n == 100) basla_i = 1'b1;
            if (n == 101) basla_i = 1'b0;
        end
        chk("t6_pulses", 32'(pulses), 1);
        chk("t6_first", 32'(first), 7426);

        // 6b: reset while dividing bin 0, then a fresh build
        fill(0);
        hist_mem[0] = 17'd38400;
        hist_mem[255] = 17'd38400;
        basla_i = 1'b1;
        @(posedge clk_i); #1;
        basla_i = 1'b0;
        repeat (270) @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        #1;
        chk_outputs_zero("t6_rst");
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_valid_after_rst", 32'(lut_gecerli_o), 0);
        chk("t6_idle_after_rst", 32'(mesgul_o), 0);
        run_build("t6b", lat);
        chk("t6b_latency", 32'(lat), 7426);
        chk("t6b_valid", 32'(lut_gecerli_o), 1);
        lut_oku(128, d); chk("t6b_lut128", 32'(d), 0);
        lut_oku(255, d); chk("t6b_lut255", 32'(d), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
